// File: rtl/jtldtest_bank_resp_pkg.sv
// Shared definitions for jtldtest_bank_resp: FSM state encoding, default timing and bank-select width.
package jtldtest_bank_resp_pkg;

  localparam int BA_W  = 2;
  localparam int NBANK = 1 << BA_W;

  localparam int DEF_TRCD       = 2;
  localparam int DEF_CL         = 2;
  localparam int DEF_REF_PERIOD = 384;
  localparam int DEF_TRFC       = 6;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ACT     = 3'd1;
  localparam state_t ST_RD_WAIT = 3'd2;
  localparam state_t ST_BEAT0   = 3'd3;
  localparam state_t ST_BEAT1   = 3'd4;
  localparam state_t ST_WR      = 3'd5;
  localparam state_t ST_REF     = 3'd6;

endpackage

// File: rtl/jtldtest_resp_mem.sv
// One bank of 16-bit byte-maskable storage; no reset so contents survive rst_n.
module jtldtest_resp_mem #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   din,
  input  logic [1:0]    mask,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   dout
);

  logic [15:0] mem [2**AW];

  // mask bit set means that byte keeps its old contents
  always_ff @(posedge clk) begin
    if (we) begin
      if (!mask[0]) mem[waddr][7:0]  <= din[7:0];
      if (!mask[1]) mem[waddr][15:8] <= din[15:8];
    end
  end

  assign dout = mem[raddr];

endmodule

// File: rtl/jtldtest_bank_resp.sv
// jtldtest_bank_resp: four-bank memory responder with a load port, per-bank ports and periodic refresh.
// Optional JTLDTEST_ERRINJ_EN: inverts bit 0 of BEAT0 data at one walking bank-1 address.
module jtldtest_bank_resp
  import jtldtest_bank_resp_pkg::*;
#(
  parameter int AW         = 10,
  parameter int TRCD       = DEF_TRCD,
  parameter int CL         = DEF_CL,
  parameter int REF_PERIOD = DEF_REF_PERIOD,
  parameter int TRFC       = DEF_TRFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        refresh_en,
  input  logic [21:0] prog_addr,
  input  logic [15:0] prog_data,
  input  logic [1:0]  prog_mask,
  input  logic [1:0]  prog_ba,
  input  logic        prog_we,
  input  logic        prog_rd,
  output logic        prog_ack,
  output logic        prog_dst,
  output logic        prog_dok,
  output logic        prog_rdy,
  input  logic [3:0]  ba_rd,
  input  logic        ba0_wr,
  input  logic [15:0] ba0_din,
  input  logic [1:0]  ba0_din_m,
  input  logic [21:0] ba0_addr,
  input  logic [21:0] ba1_addr,
  input  logic [21:0] ba2_addr,
  input  logic [21:0] ba3_addr,
  output logic [3:0]  ba_ack,
  output logic [3:0]  ba_dst,
  output logic [3:0]  ba_dok,
  output logic [3:0]  ba_rdy,
  output logic [31:0] data_read
);
  // state      | meaning
  // ST_IDLE    | arbitrate: refresh, load port, bank 0..3
  // ST_ACT     | activate delay, TRCD cycles
  // ST_RD_WAIT | read latency, CL cycles
  // ST_BEAT0   | low word fetched from addr
  // ST_BEAT1   | high word fetched from addr+1
  // ST_WR      | masked write into storage
  // ST_REF     | refresh busy, TRFC cycles

  localparam int              RW       = $clog2(REF_PERIOD);
  localparam logic [RW-1:0]   REF_LAST = RW'(REF_PERIOD - 1);
  localparam logic [7:0]      TRCD_M1  = 8'(TRCD - 1);
  localparam logic [7:0]      CL_M1    = 8'(CL - 1);
  localparam logic [7:0]      TRFC_M1  = 8'(TRFC - 1);

  state_t            state;
  logic [7:0]        tmr;
  logic [RW-1:0]     ref_cnt;
  logic              ref_pend, ref_take;
  logic              src_prog, wr_q;
  logic [BA_W-1:0]   ba_q;
  logic [AW-1:0]     addr_q, raddr;
  logic [15:0]       din_q, rd_word, beat0_word;
  logic [1:0]        mask_q;
  logic              ack_q, dst_q, dok_q, rdy_q;
  logic [15:0]       mem_dout [NBANK];

  logic              gnt, gnt_prog, gnt_wr;
  logic [BA_W-1:0]   gnt_ba;
  logic [21:0]       gnt_addr;
  logic [15:0]       gnt_din;
  logic [1:0]        gnt_mask;

  always_comb begin
    gnt      = 1'b0;
    gnt_prog = 1'b0;
    gnt_wr   = 1'b0;
    gnt_ba   = '0;
    gnt_addr = prog_addr;
    gnt_din  = prog_data;
    gnt_mask = prog_mask;
    if (prog_we || prog_rd) begin
      gnt      = 1'b1;
      gnt_prog = 1'b1;
      gnt_ba   = prog_ba;
      gnt_wr   = prog_we;
    end else if (ba0_wr || ba_rd[0]) begin
      gnt      = 1'b1;
      gnt_wr   = ba0_wr;
      gnt_addr = ba0_addr;
      gnt_din  = ba0_din;
      gnt_mask = ba0_din_m;
    end else if (ba_rd[1]) begin
      gnt      = 1'b1;
      gnt_ba   = 2'd1;
      gnt_addr = ba1_addr;
    end else if (ba_rd[2]) begin
      gnt      = 1'b1;
      gnt_ba   = 2'd2;
      gnt_addr = ba2_addr;
    end else if (ba_rd[3]) begin
      gnt      = 1'b1;
      gnt_ba   = 2'd3;
      gnt_addr = ba3_addr;
    end
  end

  // the rdy cycle is never an arbitration cycle, so a request held through rdy counts once more
  assign ref_take = (state == ST_IDLE) && !rdy_q && ref_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
    end else begin
      if (refresh_en) ref_cnt <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + 1'b1;
      if (refresh_en && ref_cnt == REF_LAST) ref_pend <= 1'b1;
      else if (ref_take)                    ref_pend <= 1'b0;
    end
  end

  assign raddr   = (state == ST_BEAT1) ? addr_q + 1'b1 : addr_q;
  assign rd_word = mem_dout[ba_q];

`ifdef JTLDTEST_ERRINJ_EN
  logic [21:0] err_addr;
  logic        hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_addr <= '0;
      hit_q    <= 1'b0;
    end else begin
      if (state == ST_IDLE && !rdy_q && !ref_pend && gnt)
        hit_q <= (gnt_ba == BA_W'(1)) && (gnt_addr == err_addr);
      if (rdy_q && ba_q == BA_W'(1)) err_addr <= err_addr + 1'b1;
    end
  end

  assign beat0_word = rd_word ^ {15'd0, hit_q};
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^gnt_addr[21:AW];
  assign beat0_word     = rd_word;
`endif

  // handshakes are registered, so each appears one cycle after the state that raises it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      src_prog  <= 1'b0;
      wr_q      <= 1'b0;
      ba_q      <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      mask_q    <= '0;
      ack_q     <= 1'b0;
      dst_q     <= 1'b0;
      dok_q     <= 1'b0;
      rdy_q     <= 1'b0;
      data_read <= '0;
    end else begin
      ack_q <= 1'b0;
      dst_q <= 1'b0;
      dok_q <= 1'b0;
      rdy_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ref_take) begin
            state <= ST_REF;
            tmr   <= TRFC_M1;
          end else if (!rdy_q && gnt) begin
            state    <= ST_ACT;
            tmr      <= TRCD_M1;
            ack_q    <= 1'b1;
            src_prog <= gnt_prog;
            wr_q     <= gnt_wr;
            ba_q     <= gnt_ba;
            addr_q   <= gnt_addr[AW-1:0];
            din_q    <= gnt_din;
            mask_q   <= gnt_mask;
          end
        end
        ST_ACT: begin
          if (tmr == '0) begin
            state <= wr_q ? ST_WR : ST_RD_WAIT;
            tmr   <= CL_M1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_RD_WAIT: begin
          if (tmr == '0) state <= ST_BEAT0;
          else           tmr   <= tmr - 1'b1;
        end
        ST_BEAT0: begin
          data_read[15:0] <= beat0_word;
          dst_q <= 1'b1;
          dok_q <= 1'b1;
          state <= ST_BEAT1;
        end
        ST_BEAT1: begin
          data_read[31:16] <= rd_word;
          rdy_q <= 1'b1;
          dok_q <= 1'b1;
          state <= ST_IDLE;
        end
        ST_WR: begin
          rdy_q <= 1'b1;
          dok_q <= 1'b1;
          state <= ST_IDLE;
        end
        ST_REF: begin
          if (tmr == '0) state <= ST_IDLE;
          else           tmr   <= tmr - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NBANK; g++) begin : g_bank
    jtldtest_resp_mem #(.AW(AW)) u_mem (
      .clk   (clk),
      .we    ((state == ST_WR) && (ba_q == BA_W'(g))),
      .waddr (addr_q),
      .din   (din_q),
      .mask  (mask_q),
      .raddr (raddr),
      .dout  (mem_dout[g])
    );
  end

  logic [3:0] bank_oh;
  assign bank_oh = 4'b0001 << ba_q;

  assign prog_ack = ack_q & src_prog;
  assign prog_dst = dst_q & src_prog;
  assign prog_dok = dok_q & src_prog;
  assign prog_rdy = rdy_q & src_prog;
  assign ba_ack   = (ack_q && !src_prog) ? bank_oh : 4'b0;
  assign ba_dst   = (dst_q && !src_prog) ? bank_oh : 4'b0;
  assign ba_dok   = (dok_q && !src_prog) ? bank_oh : 4'b0;
  assign ba_rdy   = (rdy_q && !src_prog) ? bank_oh : 4'b0;

endmodule

// File: tb/tb_jtldtest_bank_resp.sv
// Directed self-checking bench for jtldtest_bank_resp; expected values are hand-computed constants.
module tb_jtldtest_bank_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        refresh_en = 1'b0;
  logic [21:0] prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [1:0]  prog_mask = '0;
  logic [1:0]  prog_ba = '0;
  logic        prog_we = 1'b0;
  logic        prog_rd = 1'b0;
  logic        prog_ack, prog_dst, prog_dok, prog_rdy;
  logic [3:0]  ba_rd = '0;
  logic        ba0_wr = 1'b0;
  logic [15:0] ba0_din = '0;
  logic [1:0]  ba0_din_m = '0;
  logic [21:0] ba0_addr = '0, ba1_addr = '0, ba2_addr = '0, ba3_addr = '0;
  logic [3:0]  ba_ack, ba_dst, ba_dok, ba_rdy;
  logic [31:0] data_read;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtldtest_bank_resp dut (
    .clk(clk), .rst_n(rst_n), .refresh_en(refresh_en),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask), .prog_ba(prog_ba),
    .prog_we(prog_we), .prog_rd(prog_rd),
    .prog_ack(prog_ack), .prog_dst(prog_dst), .prog_dok(prog_dok), .prog_rdy(prog_rdy),
    .ba_rd(ba_rd), .ba0_wr(ba0_wr), .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
    .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
    .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
    .data_read(data_read)
  );

  function automatic logic sel_ack(input bit p, input int b);
    return p ? prog_ack : ba_ack[b];
  endfunction
  function automatic logic sel_dst(input bit p, input int b);
    return p ? prog_dst : ba_dst[b];
  endfunction
  function automatic logic sel_dok(input bit p, input int b);
    return p ? prog_dok : ba_dok[b];
  endfunction
  function automatic logic sel_rdy(input bit p, input int b);
    return p ? prog_rdy : ba_rdy[b];
  endfunction

  task automatic set_req(input bit p, input int b, input bit wr, input logic [21:0] a,
                         input logic [15:0] d, input logic [1:0] m, input bit v);
    if (p) begin
      prog_addr = a; prog_data = d; prog_mask = m; prog_ba = 2'(b);
      prog_we = v & wr; prog_rd = v & !wr;
    end else begin
      case (b)
        0:       ba0_addr = a;
        1:       ba1_addr = a;
        2:       ba2_addr = a;
        default: ba3_addr = a;
      endcase
      if (b == 0) begin
        ba0_din = d; ba0_din_m = m; ba0_wr = v & wr;
      end
      ba_rd[b] = v & !wr;
    end
  endtask

  // drives one request, drops it on ack, returns ack-relative dst/rdy latencies
  task automatic run_op(input bit p, input int b, input bit wr, input logic [21:0] a,
                        input logic [15:0] d, input logic [1:0] m,
                        output int lat_dst, output int lat_rdy, output bit dok_ok, output bit tmo);
    bit got;
    lat_dst = -1; lat_rdy = -1; dok_ok = 1'b1; tmo = 1'b0; got = 1'b0;
    @(negedge clk);
    set_req(p, b, wr, a, d, m, 1'b1);
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = sel_ack(p, b);
    end
    set_req(p, b, wr, a, d, m, 1'b0);
    if (!got) begin
      tmo = 1'b1;
      return;
    end
    for (int k = 1; k <= 40 && lat_rdy < 0; k++) begin
      @(negedge clk);
      if (sel_dst(p, b)) begin lat_dst = k; dok_ok &= sel_dok(p, b); end
      if (sel_rdy(p, b)) begin lat_rdy = k; dok_ok &= sel_dok(p, b); end
    end
    if (lat_rdy < 0) tmo = 1'b1;
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({prog_ack, prog_dst, prog_dok, prog_rdy} !== 4'b0000) begin
      errors++; $display("FAIL reset_prog_hs got=%b exp=0000", {prog_ack, prog_dst, prog_dok, prog_rdy});
    end
    checks++;
    if ({ba_ack, ba_dst, ba_dok, ba_rdy} !== 16'h0000) begin
      errors++; $display("FAIL reset_ba_hs got=%h exp=0000", {ba_ack, ba_dst, ba_dok, ba_rdy});
    end
    checks++;
    if (data_read !== 32'h0) begin
      errors++; $display("FAIL reset_data got=%h exp=00000000", data_read);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({prog_ack, ba_ack, prog_rdy, ba_rdy} !== 10'b0) begin
      errors++; $display("FAIL idle_after_reset got=%b exp=0", {prog_ack, ba_ack, prog_rdy, ba_rdy});
    end
  endtask

  task automatic test_write_read;
    bit got; int lr, ld; bit dk, to;
    // bank 0 write and read together: the write must win
    @(negedge clk);
    ba0_addr = 22'h10; ba0_din = 16'hA55A; ba0_din_m = 2'b00; ba0_wr = 1'b1; ba_rd[0] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin @(negedge clk); got = ba_ack[0]; end
    ba0_wr = 1'b0; ba_rd[0] = 1'b0;
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL wr0_ack got=%b exp=1", got); end
    lr = -1; dk = 1'b0;
    for (int k = 1; k <= 40 && lr < 0; k++) begin
      @(negedge clk);
      if (ba_rdy[0]) begin lr = k; dk = ba_dok[0]; end
    end
    checks++;
    if (lr !== 3) begin errors++; $display("FAIL wr0_rdy_lat got=%0d exp=3", lr); end
    checks++;
    if (dk !== 1'b1) begin errors++; $display("FAIL wr0_dok got=%b exp=1", dk); end

    run_op(0, 0, 1, 22'h11, 16'h5AA5, 2'b00, ld, lr, dk, to);
    checks++;
    if (data_read !== 32'h0) begin errors++; $display("FAIL data_after_write got=%h exp=00000000", data_read); end

    run_op(0, 0, 0, 22'h10, 16'h0, 2'b00, ld, lr, dk, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL rd0_timeout got=%b exp=0", to); end
    checks++;
    if (lr !== 6) begin errors++; $display("FAIL rd0_rdy_lat got=%0d exp=6", lr); end
    checks++;
    if (ld !== 5) begin errors++; $display("FAIL rd0_dst_lat got=%0d exp=5", ld); end
    checks++;
    if (dk !== 1'b1) begin errors++; $display("FAIL rd0_dok got=%b exp=1", dk); end
    checks++;
    if (data_read !== 32'h5AA5_A55A) begin errors++; $display("FAIL rd0_data got=%h exp=5aa5a55a", data_read); end

    run_op(0, 0, 1, 22'h3FF, 16'hBEEF, 2'b00, ld, lr, dk, to);
    checks++;
    if (data_read !== 32'h5AA5_A55A) begin errors++; $display("FAIL data_hold got=%h exp=5aa5a55a", data_read); end
    run_op(0, 0, 1, 22'h000, 16'hC0DE, 2'b00, ld, lr, dk, to);
    run_op(0, 0, 0, 22'h3FF, 16'h0, 2'b00, ld, lr, dk, to);
    checks++;
    if (data_read !== 32'hC0DE_BEEF) begin errors++; $display("FAIL rd_wrap got=%h exp=c0debeef", data_read); end
    run_op(0, 0, 0, 22'h3F_0010, 16'h0, 2'b00, ld, lr, dk, to);
    checks++;
    if (data_read !== 32'h5AA5_A55A) begin errors++; $display("FAIL rd_upper_ignored got=%h exp=5aa5a55a", data_read); end
  endtask

  task automatic test_mask;
    int ld, lr; bit dk, to;
    run_op(1, 2, 1, 22'h05, 16'h1234, 2'b00, ld, lr, dk, to);
    checks++;
    if (lr !== 3) begin errors++; $display("FAIL prog_wr_lat got=%0d exp=3", lr); end
    run_op(1, 2, 1, 22'h05, 16'hFFFF, 2'b10, ld, lr, dk, to);
    run_op(1, 2, 0, 22'h05, 16'h0, 2'b00, ld, lr, dk, to);
    checks++;
    if (lr !== 6) begin errors++; $display("FAIL prog_rd_lat got=%0d exp=6", lr); end
    checks++;
    if (data_read[15:0] !== 16'h12FF) begin errors++; $display("FAIL mask_data got=%h exp=12ff", data_read[15:0]); end
  endtask

  task automatic test_contention;
    int order [8];
    int nack, nrdy, overlap, hot;
    int exp_order [5];
    exp_order[0] = 4; exp_order[1] = 0; exp_order[2] = 1; exp_order[3] = 2; exp_order[4] = 3;
    nack = 0; nrdy = 0; overlap = 0;
    @(negedge clk);
    prog_addr = 22'h20; prog_ba = 2'd3; prog_rd = 1'b1;
    ba0_addr = 22'h10; ba1_addr = 22'h1; ba2_addr = 22'h2; ba3_addr = 22'h3;
    ba_rd = 4'b1111;
    for (int k = 0; k < 200 && nrdy < 5; k++) begin
      @(negedge clk);
      hot = $countones({prog_ack, prog_dst, prog_rdy, ba_ack, ba_dst, ba_rdy});
      if (hot > 1) overlap++;
      if (prog_ack) begin
        if (nack < 8) order[nack] = 4;
        nack++; prog_rd = 1'b0;
      end
      for (int j = 0; j < 4; j++) begin
        if (ba_ack[j]) begin
          if (nack < 8) order[nack] = j;
          nack++; ba_rd[j] = 1'b0;
        end
      end
      nrdy += $countones({prog_rdy, ba_rdy});
    end
    prog_rd = 1'b0; ba_rd = 4'b0;
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL cont_overlap got=%0d exp=0", overlap); end
    checks++;
    if (nack !== 5) begin errors++; $display("FAIL cont_acks got=%0d exp=5", nack); end
    checks++;
    if (nrdy !== 5) begin errors++; $display("FAIL cont_rdys got=%0d exp=5", nrdy); end
    for (int i = 0; i < 5 && i < nack; i++) begin
      checks++;
      if (order[i] !== exp_order[i]) begin
        errors++; $display("FAIL cont_order[%0d] got=%0d exp=%0d", i, order[i], exp_order[i]);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_drop;
    bit got; int a1, r3;
    @(negedge clk);
    ba3_addr = 22'h3; ba_rd[3] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin @(negedge clk); got = ba_ack[3]; end
    ba_rd[3] = 1'b0;
    @(negedge clk);
    ba1_addr = 22'h1; ba_rd[1] = 1'b1;
    @(negedge clk);
    ba_rd[1] = 1'b0;
    a1 = 0; r3 = 0;
    repeat (20) begin
      @(negedge clk);
      if (ba_ack[1]) a1++;
      if (ba_rdy[3]) r3++;
    end
    checks++;
    if (a1 !== 0) begin errors++; $display("FAIL drop_before_ack got=%0d exp=0", a1); end
    checks++;
    if (r3 !== 1) begin errors++; $display("FAIL drop_after_ack_rdy got=%0d exp=1", r3); end
  endtask

  task automatic test_back_to_back;
    int t_rdy, t_ack2;
    t_rdy = -1; t_ack2 = -1;
    @(negedge clk);
    ba1_addr = 22'h7; ba_rd[1] = 1'b1;
    for (int k = 0; k < 40 && t_ack2 < 0; k++) begin
      @(negedge clk);
      if (ba_rdy[1] && t_rdy < 0) t_rdy = k;
      if (ba_ack[1] && t_rdy >= 0) t_ack2 = k;
    end
    ba_rd[1] = 1'b0;
    checks++;
    if (t_ack2 - t_rdy !== 2) begin
      errors++; $display("FAIL held_req_regrant got=%0d exp=2 (rdy=%0d ack2=%0d)", t_ack2 - t_rdy, t_rdy, t_ack2);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_refresh;
    int last_ack, n_long, long_gap, long_at, n_acks, odd_gaps;
    pulse_reset();
    last_ack = -1; n_long = 0; long_gap = 0; long_at = -1; n_acks = 0; odd_gaps = 0;
    @(negedge clk);
    refresh_en = 1'b1; ba2_addr = 22'h2; ba_rd[2] = 1'b1;
    for (int k = 1; k <= 460; k++) begin
      @(negedge clk);
      if (ba_ack[2]) begin
        n_acks++;
        if (last_ack >= 0 && k - last_ack != 8) begin
          if (k - last_ack > 8) begin n_long++; long_gap = k - last_ack; long_at = last_ack; end
          else odd_gaps++;
        end
        last_ack = k;
      end
    end
    ba_rd[2] = 1'b0; refresh_en = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (n_long !== 1) begin errors++; $display("FAIL ref_slots got=%0d exp=1", n_long); end
    checks++;
    if (long_gap !== 15) begin errors++; $display("FAIL ref_gap got=%0d exp=15", long_gap); end
    checks++;
    if (long_at < 370 || long_at > 392) begin errors++; $display("FAIL ref_when got=%0d exp=370..392", long_at); end
    checks++;
    if (odd_gaps !== 0) begin errors++; $display("FAIL ref_short_gaps got=%0d exp=0", odd_gaps); end
  endtask

  task automatic test_reset_mid;
    bit got; int nr, ld, lr; bit dk, to;
    @(negedge clk);
    ba0_addr = 22'h10; ba_rd[0] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin @(negedge clk); got = ba_ack[0]; end
    ba_rd[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({prog_ack, prog_dst, prog_dok, prog_rdy, ba_ack, ba_dst, ba_dok, ba_rdy} !== 20'h0) begin
      errors++; $display("FAIL midreset_hs got=%h exp=0", {prog_ack, prog_dst, prog_dok, prog_rdy, ba_ack, ba_dst, ba_dok, ba_rdy});
    end
    checks++;
    if (data_read !== 32'h0) begin errors++; $display("FAIL midreset_data got=%h exp=00000000", data_read); end
    @(negedge clk);
    rst_n = 1'b1;
    nr = 0;
    repeat (12) begin @(negedge clk); nr += $countones({prog_rdy, ba_rdy}); end
    checks++;
    if (nr !== 0) begin errors++; $display("FAIL midreset_no_rdy got=%0d exp=0", nr); end
    run_op(0, 0, 0, 22'h10, 16'h0, 2'b00, ld, lr, dk, to);
    checks++;
    if (data_read[15:0] !== 16'hA55A) begin errors++; $display("FAIL midreset_intact got=%h exp=a55a", data_read[15:0]); end

    // write aborted while still in activate must not land
    @(negedge clk);
    ba0_addr = 22'h10; ba0_din = 16'hDEAD; ba0_din_m = 2'b00; ba0_wr = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin @(negedge clk); got = ba_ack[0]; end
    ba0_wr = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 0, 0, 22'h10, 16'h0, 2'b00, ld, lr, dk, to);
    checks++;
    if (data_read[15:0] !== 16'hA55A) begin errors++; $display("FAIL abort_write got=%h exp=a55a", data_read[15:0]); end
  endtask

`ifdef JTLDTEST_ERRINJ_EN
  task automatic test_errinj;
    int ld, lr; bit dk, to;
    run_op(1, 1, 1, 22'h0, 16'h0000, 2'b00, ld, lr, dk, to);
    pulse_reset();
    run_op(0, 1, 0, 22'h0, 16'h0, 2'b00, ld, lr, dk, to);
    checks++;
    if (data_read[15:0] !== 16'h0001) begin errors++; $display("FAIL errinj_first got=%h exp=0001", data_read[15:0]); end
    run_op(0, 1, 0, 22'h0, 16'h0, 2'b00, ld, lr, dk, to);
    checks++;
    if (data_read[15:0] !== 16'h0000) begin errors++; $display("FAIL errinj_repeat got=%h exp=0000", data_read[15:0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_mask();
    test_contention();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_refresh();
`ifdef JTLDTEST_ERRINJ_EN
    test_errinj();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
